// File: rtl/Uop.sv
// Uop: shared micro-op / fetch types for the front end.
//   fq_entry_t    - one fetch-queue slot (fetch PC plus fetched word).
//   fq_lane_count - length of the run of set bits starting at lane 0.
package Uop;

  localparam int unsigned IAddrW     = 32;
  // Widest push group fq_lane_count can measure.
  localparam int unsigned FqMaxLanes = 32;

  typedef logic [IAddrW-1:0] iaddr_t;

  typedef struct packed {
    logic [31:0] insn;
    logic        fault;
  } fetch_t;

  typedef struct packed {
    iaddr_t pc;
    fetch_t f;
  } fq_entry_t;

  // Leading-ones run length from lane 0; lanes after the first gap do not count.
  function automatic int unsigned fq_lane_count(input logic [FqMaxLanes-1:0] in_valid);
    int unsigned n;
    logic        run;
    n   = 0;
    run = 1'b1;
    for (int i = 0; i < int'(FqMaxLanes); i++) begin
      if (run && in_valid[i]) begin
        n = n + 1;
      end else begin
        run = 1'b0;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/fq_lane_pack.sv
// fq_lane_pack: turns a per-lane push request into the number of lanes to accept.
//   in_valid - per-lane push request, lane 0 first in program order
//   nPush    - length of the contiguous run of requests starting at lane 0
// Purely combinational; PUSH_W must not exceed Uop::FqMaxLanes.
module fq_lane_pack
  import Uop::*;
#(
  parameter  int unsigned PUSH_W = 2,
  localparam int unsigned LaneW  = $clog2(PUSH_W + 1)
) (
  input  logic [PUSH_W-1:0] in_valid,
  output logic [LaneW-1:0]  nPush
);

  logic [FqMaxLanes-1:0] padded;

  always_comb begin
    padded             = '0;
    padded[PUSH_W-1:0] = in_valid;
    nPush              = LaneW'(fq_lane_count(padded));
  end

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: multi-lane FIFO between fetch and decode.
//   clk, rst   - clock; synchronous active-high reset
//   flush      - discard all contents (branch redirect)
//   in_valid   - per-lane push request, contiguous from lane 0
//   in_data    - lane i in bits [i*ENTRY_W +: ENTRY_W]
//   in_ready   - a full PUSH_W group fits this cycle
//   out_valid  - head entry valid
//   out_data   - head entry (don't-care while out_valid is low)
//   out_ready  - decode consumes the head
//   count      - current occupancy
module fetch_queue
  import Uop::*;
#(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned PUSH_W  = 2,
  parameter int unsigned ENTRY_W = $bits(fq_entry_t)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [PUSH_W-1:0]          in_valid,
  input  logic [PUSH_W*ENTRY_W-1:0]  in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [ENTRY_W-1:0]         out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned CntW  = $clog2(DEPTH + 1);
  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned LaneW = $clog2(PUSH_W + 1);

  logic [ENTRY_W-1:0] mem [DEPTH];

  logic [PtrW-1:0]  wrPtr, wrPtrNext;
  logic [PtrW-1:0]  rdPtr, rdPtrNext;
  logic [CntW-1:0]  cnt, cntNext;
  logic [LaneW-1:0] laneRun;
  logic [LaneW-1:0] nPush;
  logic             pop;

  // Explicit wrap, so DEPTH need not be a power of two. inc never exceeds DEPTH-1.
  function automatic logic [PtrW-1:0] ptrAdd(input logic [PtrW-1:0] base,
                                             input int unsigned     inc);
    int unsigned sum;
    sum = 32'(base) + inc;
    if (sum >= DEPTH) begin
      sum = sum - DEPTH;
    end
    return PtrW'(sum);
  endfunction

  fq_lane_pack #(
    .PUSH_W (PUSH_W)
  ) u_lane_pack (
    .in_valid (in_valid),
    .nPush    (laneRun)
  );

  always_comb begin
    // Registered count only: a same-cycle pop never frees room for a push.
    in_ready  = (DEPTH - 32'(cnt)) >= PUSH_W;
    out_valid = (cnt != '0);
    out_data  = mem[rdPtr];
    count     = cnt;
    nPush     = in_ready ? laneRun : '0;
    pop       = out_valid && out_ready;
    wrPtrNext = ptrAdd(wrPtr, 32'(nPush));
    rdPtrNext = pop ? ptrAdd(rdPtr, 32'd1) : rdPtr;
    cntNext   = cnt + CntW'(nPush) - CntW'(pop);
  end

  // rst and flush give the same result; rst simply wins when both are high.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      cnt   <= '0;
    end else begin
      wrPtr <= wrPtrNext;
      rdPtr <= rdPtrNext;
      cnt   <= cntNext;
    end
  end

  // Storage carries no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      for (int i = 0; i < int'(PUSH_W); i++) begin
        if (unsigned'(i) < 32'(nPush)) begin
          mem[ptrAdd(wrPtr, unsigned'(i))] <= in_data[i*ENTRY_W +: ENTRY_W];
        end
      end
    end
  end

endmodule
